// File: rtl/ab_seq_pkg.sv
// Shared types, default parameters and helpers for the ab_seq_gen pattern transmitter.
package ab_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } ab_seq_state_t;

    localparam int AB_MAX_LEN = 16;
    localparam int AB_LEN_W   = 5;
    localparam int AB_REP_W   = 4;
    localparam int AB_GAP_CYC = 2;

    // Saturates a requested pass length to the width of the pattern registers.
    function automatic int ab_clamp_len(input int req_len, input int max_len);
        return (req_len > max_len) ? max_len : req_len;
    endfunction

endpackage

// File: rtl/ab_shift_reg.sv
// Two-lane load-and-shift register; lane bit 0 is the bit currently presented on a/b.
module ab_shift_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_a,
    input  logic [WIDTH-1:0] load_b,
    output logic             lsb_a,
    output logic             lsb_b
);

    logic [WIDTH-1:0] sr_a;
    logic [WIDTH-1:0] sr_b;

    // Load takes priority so a new pass can start on the same edge the old one ends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_a <= '0;
            sr_b <= '0;
        end else if (load) begin
            sr_a <= load_a;
            sr_b <= load_b;
        end else if (shift) begin
            sr_a <= {1'b0, sr_a[WIDTH-1:1]};
            sr_b <= {1'b0, sr_b[WIDTH-1:1]};
        end
    end

    assign lsb_a = sr_a[0];
    assign lsb_b = sr_b[0];

endmodule

// File: rtl/ab_seq_gen.sv
// Programmable two-lane serial pattern transmitter feeding the a/b inputs of a sequence detector.
module ab_seq_gen
    import ab_seq_pkg::*;
#(
    parameter int MAX_LEN = AB_MAX_LEN,
    parameter int LEN_W   = AB_LEN_W,
    parameter int REP_W   = AB_REP_W,
    parameter int GAP_CYC = AB_GAP_CYC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pat_a,
    input  logic [MAX_LEN-1:0] pat_b,
    input  logic [LEN_W-1:0]   len,
    input  logic [REP_W-1:0]   reps,
    output logic               a,
    output logic               b,
    output logic               busy,
    output logic               done,
    output logic [LEN_W-1:0]   bit_idx
);

    localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    ab_seq_state_t    state_q, state_d;
    logic [MAX_LEN-1:0] pat_a_q, pat_b_q;
    logic [LEN_W-1:0] len_eff_q;
    logic [REP_W-1:0] reps_eff_q;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [LEN_W-1:0] bit_idx_q, bit_idx_d;
    logic             busy_q, done_q;

    logic             latch;
    logic             last_bit;
    logic             sr_load, sr_shift;
    logic [MAX_LEN-1:0] sr_data_a, sr_data_b;
    logic [LEN_W-1:0] len_eff_d;
    logic [REP_W-1:0] reps_eff_d;

    assign len_eff_d  = LEN_W'(ab_clamp_len(int'(len), MAX_LEN));
    assign reps_eff_d = (reps == '0) ? REP_W'(1) : reps;
    assign last_bit   = (bit_idx_q == len_eff_q - 1'b1);

    // Next-state and control: loading zeros into the shifter is how a/b are forced low outside SHIFT.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        rep_cnt_d = rep_cnt_q;
        gap_cnt_d = gap_cnt_q;
        latch     = 1'b0;
        sr_load   = 1'b0;
        sr_shift  = 1'b0;
        sr_data_a = '0;
        sr_data_b = '0;
        case (state_q)
            IDLE: begin
                bit_idx_d = '0;
                if (start && (len != '0)) begin
                    latch     = 1'b1;
                    state_d   = SHIFT;
                    rep_cnt_d = REP_W'(1);
                    sr_load   = 1'b1;
                    sr_data_a = pat_a;
                    sr_data_b = pat_b;
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    bit_idx_d = bit_idx_q + 1'b1;
                    sr_shift  = 1'b1;
                end else if (rep_cnt_q == reps_eff_q) begin
                    state_d   = DONE;
                    bit_idx_d = '0;
                    sr_load   = 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                    bit_idx_d = '0;
                    sr_load   = 1'b1;
                    if (GAP_CYC == 0) begin
                        sr_data_a = pat_a_q;
                        sr_data_b = pat_b_q;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d   = SHIFT;
                    bit_idx_d = '0;
                    sr_load   = 1'b1;
                    sr_data_a = pat_a_q;
                    sr_data_b = pat_b_q;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d   = IDLE;
                bit_idx_d = '0;
            end
            default: begin
                state_d   = IDLE;
                bit_idx_d = '0;
            end
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            rep_cnt_q <= '0;
            gap_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            rep_cnt_q <= rep_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            busy_q    <= (state_d == SHIFT) || (state_d == GAP);
            done_q    <= (state_d == DONE);
        end
    end

    // Transfer parameters are captured once so later input changes cannot disturb a transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_a_q    <= '0;
            pat_b_q    <= '0;
            len_eff_q  <= '0;
            reps_eff_q <= '0;
        end else if (latch) begin
            pat_a_q    <= pat_a;
            pat_b_q    <= pat_b;
            len_eff_q  <= len_eff_d;
            reps_eff_q <= reps_eff_d;
        end
    end

    ab_shift_reg #(
        .WIDTH (MAX_LEN)
    ) u_shift (
        .clk    (clk),
        .reset  (reset),
        .load   (sr_load),
        .shift  (sr_shift),
        .load_a (sr_data_a),
        .load_b (sr_data_b),
        .lsb_a  (a),
        .lsb_b  (b)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign bit_idx = bit_idx_q;

endmodule

// File: tb/tb_ab_seq_gen.sv
// Self-checking bench for ab_seq_gen: per-cycle comparison against a pattern-level model plus literal checks.
module tb_ab_seq_gen;

    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;
    localparam int REP_W   = 4;
    localparam int GAP     = 2;
    localparam int REC_N   = 4096;

    typedef struct {
        logic a;
        logic b;
        logic busy;
        logic done;
        int   idx;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic [MAX_LEN-1:0] pat_a = '0;
    logic [MAX_LEN-1:0] pat_b = '0;
    logic [LEN_W-1:0]   len = '0;
    logic [REP_W-1:0]   reps = '0;
    logic               a, b, busy, done;
    logic [LEN_W-1:0]   bit_idx;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    logic rec_a[REC_N];
    logic rec_b[REC_N];
    logic rec_busy[REC_N];
    logic rec_done[REC_N];

    ab_seq_gen #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .REP_W   (REP_W),
        .GAP_CYC (GAP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .pat_a   (pat_a),
        .pat_b   (pat_b),
        .len     (len),
        .reps    (reps),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .bit_idx (bit_idx)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Expected waveform of one transfer, built from the pass/gap/done rules.
    task automatic model_push(input logic [MAX_LEN-1:0] pa, input logic [MAX_LEN-1:0] pb,
                              input int l, input int r);
        int   le;
        int   re;
        exp_t e;
        le = (l > MAX_LEN) ? MAX_LEN : l;
        re = (r == 0) ? 1 : r;
        if (le == 0) return;
        for (int p = 0; p < re; p++) begin
            for (int k = 0; k < le; k++) begin
                e = '{a: pa[k], b: pb[k], busy: 1'b1, done: 1'b0, idx: k};
                exp_q.push_back(e);
            end
            if (p < re - 1) begin
                for (int g = 0; g < GAP; g++) begin
                    e = '{a: 1'b0, b: 1'b0, busy: 1'b1, done: 1'b0, idx: 0};
                    exp_q.push_back(e);
                end
            end
        end
        e = '{a: 1'b0, b: 1'b0, busy: 1'b0, done: 1'b1, idx: 0};
        exp_q.push_back(e);
    endtask

    // Drives a one-cycle start; s is the record index at which bit 0 will appear.
    task automatic apply_stimulus(input logic [MAX_LEN-1:0] pa, input logic [MAX_LEN-1:0] pb,
                                  input int l, input int r, output int s);
        @(negedge clk);
        pat_a = pa;
        pat_b = pb;
        len   = LEN_W'(l);
        reps  = REP_W'(r);
        start = 1'b1;
        s     = cyc;
        model_push(pa, pb, l, r);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        check_output("model_drained", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    function automatic int count_busy(input int s, input int w);
        int n = 0;
        for (int i = s; i < s + w && i < REC_N; i++) if (rec_busy[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_done(input int s, input int w);
        int n = 0;
        for (int i = s; i < s + w && i < REC_N; i++) if (rec_done[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic logic [31:0] pack_a(input int s, input int w);
        logic [31:0] v = '0;
        for (int i = 0; i < w; i++) v[i] = rec_a[s + i];
        return v;
    endfunction

    function automatic logic [31:0] pack_b(input int s, input int w);
        logic [31:0] v = '0;
        for (int i = 0; i < w; i++) v[i] = rec_b[s + i];
        return v;
    endfunction

    // Per-cycle compare; an empty model queue means the block must look idle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '{a: 1'b0, b: 1'b0, busy: 1'b0, done: 1'b0, idx: 0};
            check_output("a", a, e.a);
            check_output("b", b, e.b);
            check_output("busy", busy, e.busy);
            check_output("done", done, e.done);
            if (e.busy) check_output("bit_idx", bit_idx, e.idx);
            if (cyc < REC_N) begin
                rec_a[cyc]    = a;
                rec_b[cyc]    = b;
                rec_busy[cyc] = busy;
                rec_done[cyc] = done;
            end
            cyc++;
        end
    end

    initial begin
        int s;

        repeat (3) @(negedge clk);
        reset = 1'b1;
        s = cyc;
        repeat (10) @(negedge clk);
        check_output("idle_busy_cnt", count_busy(s, 10), 0);
        check_output("idle_done_cnt", count_done(s, 10), 0);

        apply_stimulus(16'h000B, 16'h0006, 4, 1, s);
        wait_drain();
        check_output("single_a_seq", pack_a(s, 4), 32'h0000000B);
        check_output("single_b_seq", pack_b(s, 4), 32'h00000006);
        check_output("single_busy_cnt", count_busy(s, 8), 4);
        check_output("single_done_pos", rec_done[s + 4], 1'b1);
        check_output("single_done_cnt", count_done(s, 8), 1);

        apply_stimulus(16'h0005, 16'h0003, 3, 2, s);
        wait_drain();
        check_output("rep_a_seq", pack_a(s, 8), 32'h000000A5);
        check_output("rep_busy_cnt", count_busy(s, 12), 8);
        check_output("rep_done_cnt", count_done(s, 12), 1);

        apply_stimulus(16'hFFFF, 16'hFFFF, 0, 1, s);
        repeat (6) @(negedge clk);
        check_output("len0_busy_cnt", count_busy(s, 6), 0);
        check_output("len0_done_cnt", count_done(s, 6), 0);

        apply_stimulus(16'hA5C3, 16'h3C5A, 20, 1, s);
        wait_drain();
        check_output("clamp_busy_cnt", count_busy(s, 22), 16);
        check_output("clamp_a_seq", pack_a(s, 16), 32'h0000A5C3);

        apply_stimulus(16'h0017, 16'h0009, 5, 0, s);
        wait_drain();
        check_output("reps0_busy_cnt", count_busy(s, 12), 5);

        apply_stimulus(16'h0096, 16'h0069, 8, 1, s);
        @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        pat_a = 16'hFF00;
        pat_b = 16'h00FF;
        len   = 5'd3;
        @(negedge clk);
        start = 1'b0;
        pat_a = 16'h1234;
        wait_drain();
        check_output("abuse_a_seq", pack_a(s, 8), 32'h00000096);
        check_output("abuse_b_seq", pack_b(s, 8), 32'h00000069);

        apply_stimulus(16'h00D7, 16'h0028, 8, 1, s);
        repeat (5) @(posedge clk);
        #2;
        check_output("pre_reset_idx", bit_idx, 5);
        reset = 1'b0;
        exp_q.delete();
        #1;
        check_output("rst_a", a, 1'b0);
        check_output("rst_b", b, 1'b0);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_idx", bit_idx, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_output("rst_no_done", count_done(s, cyc - s), 0);

        apply_stimulus(16'h00D7, 16'h0028, 8, 1, s);
        wait_drain();
        check_output("restart_a_seq", pack_a(s, 8), 32'h000000D7);
        check_output("restart_done_pos", rec_done[s + 8], 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
